// File: rtl/ws_psum_accumulator.sv
// Weight-stationary partial-sum accumulator: groups cfg_len sums, requantizes
// (rounding shift, optional ReLU via PSUM_RELU_EN, saturation) and buffers results in a FIFO.
module ws_psum_accumulator #(
    parameter int WIDTH   = 19,
    parameter int LEN_W   = 6,
    parameter int ACC_W   = WIDTH + LEN_W,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               sum_iv,
    input  logic [WIDTH-1:0]   sum_id,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [SHIFT_W-1:0] cfg_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               busy,
    output logic               ovf
);
    localparam int CNT_W  = LEN_W + 1;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int STAGES = 2;
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

    // vld_pipe[0]: acc holds a finished group; vld_pipe[1]: q_q holds its requantized value
    logic [STAGES-1:0]     vld_pipe;
    logic [CNT_W-1:0]      cnt, len_q, cfg_len_full, cur_len;
    logic [SHIFT_W-1:0]    shift_q;
    logic [ACC_W-1:0]      acc, sum_ext;
    logic                  last;
    logic signed [ACC_W:0] acc_x, rnd, rsum, r;
    logic [OUT_W-1:0]      q_data, q_q;

    assign cfg_len_full = (cfg_len == '0) ? CNT_W'(1 << LEN_W) : {1'b0, cfg_len};
    assign cur_len      = (cnt == '0) ? cfg_len_full : len_q;
    assign last         = sum_iv && (cnt == cur_len - 1'b1);
    assign sum_ext      = {{(ACC_W-WIDTH){sum_id[WIDTH-1]}}, sum_id};
    assign busy         = (cnt != '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt         <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            acc         <= '0;
            vld_pipe[0] <= 1'b0;
        end else begin
            vld_pipe[0] <= last;
            if (sum_iv) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (cnt == '0) begin
                    acc     <= sum_ext;
                    len_q   <= cfg_len_full;
                    shift_q <= cfg_shift;
                end else begin
                    acc <= acc + sum_ext;
                end
            end
        end
    end

    // shift_q still belongs to the finished group here: a new group's first
    // beat can only update it at the end of this same cycle.
    always_comb begin
        acc_x  = {acc[ACC_W-1], acc};
        rnd    = (shift_q != '0) ? ((ACC_W+1)'(1) << (shift_q - 1'b1)) : '0;
        rsum   = acc_x + rnd;
        r      = rsum >>> shift_q;
`ifdef PSUM_RELU_EN
        if (r < 0) r = '0;
`endif
        if (r > SAT_HI)      q_data = SAT_HI[OUT_W-1:0];
        else if (r < SAT_LO) q_data = SAT_LO[OUT_W-1:0];
        else                 q_data = r[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q_q         <= '0;
            vld_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) q_q <= q_data;
        end
    end

    // Shift-register FIFO: entry 0 is the head, vacated slots are zeroed so
    // out_data reads 0 when empty.
    logic [OUT_W-1:0] mem    [DEPTH];
    logic [OUT_W-1:0] mem_nx [DEPTH];
    logic [CW-1:0]    count, widx;
    logic             push, pop, full, push_ok;

    assign push      = vld_pipe[1];
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign full      = (count == CW'(DEPTH));
    assign push_ok   = push && (!full || pop);
    assign widx      = pop ? count - 1'b1 : count;
    assign out_data  = mem[0];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_nx[i] = mem[i];
        if (pop) begin
            for (int i = 0; i < DEPTH-1; i++) mem_nx[i] = mem[i+1];
            mem_nx[DEPTH-1] = '0;
        end
        if (push_ok) mem_nx[widx[CW-2:0]] = q_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nx[i];
            count <= count + CW'(push_ok) - CW'(pop);
            if (push && full && !pop) ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ws_psum_accumulator.sv
// Self-checking bench for ws_psum_accumulator: vector table plus hand sequences,
// results checked through a scoreboard queue at the output handshake.
module tb_ws_psum_accumulator;
    logic        clk = 1'b0;
    logic        nrst;
    logic        sum_iv;
    logic [18:0] sum_id;
    logic [5:0]  cfg_len;
    logic [4:0]  cfg_shift;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        ovf;

    ws_psum_accumulator dut (
        .clk(clk), .nrst(nrst), .sum_iv(sum_iv), .sum_id(sum_id),
        .cfg_len(cfg_len), .cfg_shift(cfg_shift), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int chk = 0;
    int err = 0;
    int exp_q[$];
    int busy_cnt = 0;
    int mon_e;

    typedef struct {
        int len;
        int shift;
        int n;
        int s[4];
        int exp;
        int exp_relu;
    } vec_t;
    vec_t vt[9];

    // Output monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (nrst) begin
            if (busy) busy_cnt++;
            if (out_valid && out_ready) begin
                chk++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL out_unexpected got %0d expected none", int'($signed(out_data)));
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'($signed(out_data)) != mon_e) begin
                        err++;
                        $display("FAIL out_data got %0d expected %0d", int'($signed(out_data)), mon_e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int v);
        sum_iv = 1'b1;
        sum_id = 19'(v);
        tick();
        sum_iv = 1'b0;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk++;
        if (exp_q.size() != 0) begin
            err++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        vt[0] = '{3, 0, 3, '{10, 20, -5, 0}, 25, 25};
        vt[1] = '{1, 2, 1, '{7, 0, 0, 0}, 2, 2};
        vt[2] = '{1, 2, 1, '{6, 0, 0, 0}, 2, 2};
        vt[3] = '{1, 2, 1, '{-7, 0, 0, 0}, -2, 0};
        vt[4] = '{2, 0, 2, '{150, 50, 0, 0}, 127, 127};
        vt[5] = '{2, 0, 2, '{-200, -100, 0, 0}, -128, 0};
        vt[6] = '{4, 3, 4, '{100, -3, 7, 0}, 13, 13};
        vt[7] = '{1, 0, 1, '{-300, 0, 0, 0}, -128, 0};
        vt[8] = '{2, 4, 2, '{-8, -8, 0, 0}, -1, 0};

        nrst = 1'b0; sum_iv = 1'b0; sum_id = '0; cfg_len = '0; cfg_shift = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        @(negedge clk) nrst = 1'b1;
        tick();

        // Latency and busy duration for a 3-beat group
        busy_cnt = 0;
        cfg_len = 6'd3; cfg_shift = 5'd0;
        beat(10);
        beat(20);
        exp_q.push_back(25);
        beat(-5);
        tick();
        check("lat_valid_t2", int'(out_valid), 0);
        tick();
        check("lat_valid_t3", int'(out_valid), 1);
        repeat (3) tick();
        check("busy_cycles", busy_cnt, 2);
        wait_drain();

        // Vector table, groups back to back
        for (int v = 0; v < 9; v++) begin
            cfg_len = 6'(vt[v].len);
            cfg_shift = 5'(vt[v].shift);
            for (int j = 0; j < vt[v].n; j++) begin
                if (j == vt[v].n - 1) begin
`ifdef PSUM_RELU_EN
                    exp_q.push_back(vt[v].exp_relu);
`else
                    exp_q.push_back(vt[v].exp);
`endif
                end
                beat(vt[v].s[j]);
            end
        end
        wait_drain();

        // Full FIFO: fifth result dropped, ovf set, drain in order
        out_ready = 1'b0;
        cfg_len = 6'd1; cfg_shift = 5'd0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(k);
            beat(k);
        end
        repeat (4) tick();
        check("full_valid", int'(out_valid), 1);
        check("full_ovf", int'(ovf), 1);
        check("full_head", int'($signed(out_data)), 1);
        tick();
        check("full_head_stable", int'($signed(out_data)), 1);
        out_ready = 1'b1;
        wait_drain();
        repeat (2) tick();
        check("drained_valid", int'(out_valid), 0);
        check("ovf_sticky", int'(ovf), 1);

        // Gaps inside a group; cfg_len change mid-group ignored
        cfg_len = 6'd2; cfg_shift = 5'd0;
        beat(3);
        check("gap_busy_mid", int'(busy), 1);
        repeat (2) tick();
        cfg_len = 6'd1;
        exp_q.push_back(7);
        beat(4);
        check("gap_busy_done", int'(busy), 0);
        tick();
        exp_q.push_back(9);
        beat(9);
        check("len1_busy", int'(busy), 0);
        wait_drain();

        // cfg_len = 0 means 64 sums per group
        cfg_len = 6'd0; cfg_shift = 5'd1;
        for (int k = 0; k < 64; k++) begin
            if (k == 63) exp_q.push_back(64);
            beat(2);
            if (k == 62) check("len64_busy", int'(busy), 1);
        end
        check("len64_busy_done", int'(busy), 0);
        wait_drain();

        // Reset mid-group with a result sitting in the FIFO
        out_ready = 1'b0;
        cfg_len = 6'd1; cfg_shift = 5'd0;
        beat(50);
        cfg_len = 6'd4;
        beat(1);
        beat(1);
        repeat (3) tick();
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_busy", int'(busy), 1);
        nrst = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        @(negedge clk) nrst = 1'b1;
        tick();
        out_ready = 1'b1;
        cfg_len = 6'd4;
        beat(1);
        beat(1);
        beat(1);
        exp_q.push_back(4);
        beat(1);
        wait_drain();
        repeat (3) tick();
        check("final_valid", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule

// File: doc/ws_psum_accumulator.md
# ws_psum_accumulator

Downstream consumer of the weight-stationary three-port pipelined adder. It accumulates a programmable number of consecutive valid partial sums (one per input-channel group) into one output-pixel value. Each completed value is requantized: rounding arithmetic right shift, optional ReLU, then saturation to OUT_W. Results are buffered in a small FIFO and drained through a valid/ready handshake, because the adder column has no backpressure.

## Interface
- WIDTH, 19: signed width of incoming partial sums; matches adder output.
- LEN_W, 6: width of `cfg_len`; a group holds at most 2^LEN_W sums.
- ACC_W, WIDTH+LEN_W: signed accumulator width.
- OUT_W, 8: signed output width.
- SHIFT_W, 5: width of `cfg_shift`.
- DEPTH, 4: result FIFO entries (power of two, ≥2).

- clk  in  1  clock, all logic on rising edge.
- nrst  in  1  asynchronous active-low reset.
- sum_iv  in  1  partial-sum valid (adder `sum_ov`).
- sum_id  in  WIDTH  signed partial sum (adder `sum_od`).
- cfg_len  in  LEN_W  sums per group; 0 encodes 2^LEN_W.
- cfg_shift  in  SHIFT_W  right-shift amount for requantization.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts `out_data` this cycle.
- out_data  out  OUT_W  signed requantized result (FIFO head).
- busy  out  1  a group is partially accumulated.
- ovf  out  1  sticky: a result was dropped on a full FIFO.

## Operation
- Group counter `cnt` (LEN_W+1 bits) and accumulator `acc` (ACC_W). Both reset to 0.
- First beat of a group (`sum_iv` with `cnt==0`):
  - latch `cfg_len` and `cfg_shift` into `len_q`/`shift_q`;
  - set `acc = sign_extend(sum_id)`.
- Later beats: `acc = acc + sign_extend(sum_id)`.
- `cfg_*` changes mid-group have no effect on the current group.
- The beat where `cnt == len_q-1` completes the group:
  - `cnt` returns to 0;
  - a `done` flag registers with `acc`.
- `sum_iv` low: hold all state; gaps inside a group are legal.
- Arithmetic: two's complement, ACC_W bits. Overflow only occurs beyond 2^LEN_W full-scale sums and wraps without detection.
- Requantize stage (registered):
  - `r = (acc + (shift_q>0 ? 1<<(shift_q-1) : 0)) >>> shift_q`, evaluated at ACC_W+1 bits;
  - apply ReLU if compiled in;
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- FIFO push happens the cycle after the requantize stage.
  - Push on full without a same-cycle pop: drop the result and set `ovf`.
  - Push and pop in the same cycle on full: both succeed.
- `ovf` clears only on reset.
- `busy = (cnt != 0)`.
- Reset mid-group discards the partial sum, all FIFO contents, and `ovf`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `busy=0`, `ovf=0`.
- Last beat of a group accepted in cycle t:
  - `acc`/`done` valid in t+1;
  - requantized value registered in t+2;
  - FIFO written at end of t+2;
  - `out_valid` high in t+3 (FIFO previously empty).
- Throughput: one group per cycle with `cfg_len=1`. No input stall is possible.
- Handshake: a transfer occurs when `out_valid && out_ready`. `out_data` is stable while `out_valid && !out_ready`.
- `out_data` is the registered FIFO head. It is 0 when the FIFO is empty.

## Configuration
- `PSUM_RELU_EN` defined: negative `r` is forced to 0 before saturation, so `out_data` is never negative.
- `PSUM_RELU_EN` undefined: signed saturation only, and negative results pass through.

## Test plan
- `cfg_len=3`, `cfg_shift=0`, sums 10, 20, -5 on consecutive cycles, `out_ready=1` → `out_data=25` with `out_valid` high three cycles after the last beat; `busy` high for exactly two cycles.
- `cfg_len=1`, `cfg_shift=2`, sums 7, 6, -7 → outputs 2, 2, -2 (round-half-up), one per cycle.
- `cfg_len=2`, `shift=0`, sums 150+50, then -200+-100 → 127, then -128 (ReLU build: 127, 0).
- `out_ready=0`, `cfg_len=1`, 5 sums 1..5 → FIFO holds 1..4, `ovf=1`; raising `out_ready` drains 1, 2, 3, 4 in order, then `out_valid=0`.
- Sums spaced with idle gaps, `cfg_len` changed 2→1 after the first beat → group completes after 2 beats with the correct total; the next group uses length 1.
- `nrst` pulsed after 2 of 4 beats → all outputs 0; a following fresh 4-beat group of 1s yields exactly 4.
